// File: rtl/ftdi_emu_pkg.sv
// Shared types and constants for the FT245-style FIFO emulator.
// FSM state encodings, the data byte width and the precharge counter width.
package ftdi_emu_pkg;

   localparam int BYTE_W    = 8;
   localparam int PRE_CNT_W = 4;

   typedef enum logic [1:0] {
      R_IDLE,
      R_DRIVE,
      R_PRE
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_STROBE,
      W_PRE
   } wr_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a count register and a head that reflects registered state.
// Pushes when full and pops when empty are ignored.
module byte_fifo
   import ftdi_emu_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [BYTE_W-1:0]     push_data,
   input  logic                  pop,
   output logic [BYTE_W-1:0]     head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [BYTE_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   cnt;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (cnt == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ftdi_fifo_emu.sv
// FT245-style FIFO device emulator answering the controller's RD/WR strobes (active-high nets).
// Define FTDI_EMU_LOOPBACK_EN to forward TX bytes straight into RX and disable the host ports.
module ftdi_fifo_emu
   import ftdi_emu_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int PRECHARGE  = 2
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_ftdi_rd,
   input  logic              in_ftdi_wr,
   output logic              out_ftdi_rxf,
   output logic              out_ftdi_txe,
   input  logic [BYTE_W-1:0] in_ftdi_data,
   output logic [BYTE_W-1:0] out_ftdi_data,
   output logic              out_ftdi_data_oe,
   input  logic [BYTE_W-1:0] in_host_data,
   input  logic              in_host_valid,
   output logic              out_host_ready,
   output logic [BYTE_W-1:0] out_host_data,
   output logic              out_host_valid,
   input  logic              in_host_ready,
   output logic              out_proto_err
);

   localparam logic [PRE_CNT_W-1:0] PRE_LOAD = PRE_CNT_W'(PRECHARGE - 1);

   logic                  alive;
   logic                  rx_push, rx_pop, rx_full, rx_empty;
   logic                  tx_push, tx_pop, tx_full, tx_empty;
   logic [BYTE_W-1:0]     rx_push_data, rx_head, tx_head;
   logic [DEPTH_LOG2:0]   rx_count, tx_count;

   rd_state_e             r_state, r_state_nxt;
   logic [PRE_CNT_W-1:0]  r_cnt, r_cnt_nxt;
   logic [BYTE_W-1:0]     rd_data, rd_data_nxt;
   logic                  rd_oe, rd_oe_nxt;

   wr_state_e             w_state, w_state_nxt;
   logic [PRE_CNT_W-1:0]  w_cnt, w_cnt_nxt;
   logic [BYTE_W-1:0]     w_sample, w_sample_nxt;

   logic                  proto_err, proto_err_nxt;

   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk(in_clk), .rst(in_rst), .push(rx_push), .push_data(rx_push_data), .pop(rx_pop),
      .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk(in_clk), .rst(in_rst), .push(tx_push), .push_data(w_sample), .pop(tx_pop),
      .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

`ifdef FTDI_EMU_LOOPBACK_EN
   assign rx_push        = ~tx_empty & ~rx_full;
   assign rx_push_data   = tx_head;
   assign tx_pop         = rx_push;
   assign out_host_ready = 1'b0;
   assign out_host_valid = 1'b0;
   assign out_host_data  = '0;
`else
   assign out_host_ready = alive & ~rx_full;
   assign out_host_valid = ~tx_empty;
   assign out_host_data  = tx_head;
   assign rx_push        = in_host_valid & out_host_ready;
   assign rx_push_data   = in_host_data;
   assign tx_pop         = out_host_valid & in_host_ready;
`endif

   // Flags come from registered state, so an async reset drops them immediately.
   assign out_ftdi_rxf     = (r_state == R_IDLE) & ~rx_empty;
   assign out_ftdi_txe     = alive & (w_state == W_IDLE) & ~tx_full;
   assign out_ftdi_data    = rd_data;
   assign out_ftdi_data_oe = rd_oe;
   assign out_proto_err    = proto_err;

   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      r_state_nxt = r_state;
      r_cnt_nxt   = r_cnt;
      rd_data_nxt = rd_data;
      rd_oe_nxt   = rd_oe;
      rx_pop      = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            if (in_ftdi_rd && out_ftdi_rxf) begin
               r_state_nxt = R_DRIVE;
               rd_data_nxt = rx_head;
               rd_oe_nxt   = 1'b1;
            end
         end
         R_DRIVE: begin
            if (!in_ftdi_rd) begin
               rx_pop      = 1'b1;
               rd_oe_nxt   = 1'b0;
               r_cnt_nxt   = PRE_LOAD;
               r_state_nxt = R_PRE;
            end
         end
         R_PRE: begin
            if (r_cnt == '0) r_state_nxt = R_IDLE;
            else             r_cnt_nxt   = r_cnt - 1'b1;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_nxt  = w_state;
      w_cnt_nxt    = w_cnt;
      w_sample_nxt = w_sample;
      tx_push      = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            if (in_ftdi_wr && out_ftdi_txe) begin
               w_state_nxt  = W_STROBE;
               w_sample_nxt = in_ftdi_data;
            end
         end
         W_STROBE: begin
            // The byte is committed on the trailing edge of WR, using the last sample taken with WR high.
            if (in_ftdi_wr) begin
               w_sample_nxt = in_ftdi_data;
            end else begin
               tx_push     = 1'b1;
               w_cnt_nxt   = PRE_LOAD;
               w_state_nxt = W_PRE;
            end
         end
         W_PRE: begin
            if (w_cnt == '0) w_state_nxt = W_IDLE;
            else             w_cnt_nxt   = w_cnt - 1'b1;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      proto_err_nxt = proto_err
                    | (in_ftdi_rd & ((r_state == R_PRE) | ((r_state == R_IDLE) & ~out_ftdi_rxf)))
                    | (in_ftdi_wr & ((w_state == W_PRE) | ((w_state == W_IDLE) & ~out_ftdi_txe)))
                    | (in_ftdi_rd & in_ftdi_wr);
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         alive     <= 1'b0;
         r_state   <= R_IDLE;
         r_cnt     <= '0;
         rd_data   <= '0;
         rd_oe     <= 1'b0;
         w_state   <= W_IDLE;
         w_cnt     <= '0;
         w_sample  <= '0;
         proto_err <= 1'b0;
      end else begin
         alive     <= 1'b1;
         r_state   <= r_state_nxt;
         r_cnt     <= r_cnt_nxt;
         rd_data   <= rd_data_nxt;
         rd_oe     <= rd_oe_nxt;
         w_state   <= w_state_nxt;
         w_cnt     <= w_cnt_nxt;
         w_sample  <= w_sample_nxt;
         proto_err <= proto_err_nxt;
      end
   end

endmodule

// File: tb/tb_ftdi_fifo_emu.sv
// Scoreboard bench for ftdi_fifo_emu: directed strobes, expected bytes queued at stimulus time.
// Build with FTDI_EMU_LOOPBACK_EN to exercise the loopback variant instead of the host-port tests.
module tb_ftdi_fifo_emu;

   localparam int PRE = 2;

   logic       in_clk = 1'b0;
   logic       in_rst = 1'b0;
   logic       in_ftdi_rd = 1'b0;
   logic       in_ftdi_wr = 1'b0;
   logic       out_ftdi_rxf;
   logic       out_ftdi_txe;
   logic [7:0] in_ftdi_data = 8'h00;
   logic [7:0] out_ftdi_data;
   logic       out_ftdi_data_oe;
   logic [7:0] in_host_data = 8'h00;
   logic       in_host_valid = 1'b0;
   logic       out_host_ready;
   logic [7:0] out_host_data;
   logic       out_host_valid;
   logic       in_host_ready = 1'b0;
   logic       out_proto_err;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_rd_q[$];
   logic [7:0] exp_tx_q[$];
   logic       oe_prev = 1'b0;

   ftdi_fifo_emu #(.DEPTH_LOG2(4), .PRECHARGE(PRE)) dut (
      .in_clk(in_clk), .in_rst(in_rst),
      .in_ftdi_rd(in_ftdi_rd), .in_ftdi_wr(in_ftdi_wr),
      .out_ftdi_rxf(out_ftdi_rxf), .out_ftdi_txe(out_ftdi_txe),
      .in_ftdi_data(in_ftdi_data), .out_ftdi_data(out_ftdi_data),
      .out_ftdi_data_oe(out_ftdi_data_oe),
      .in_host_data(in_host_data), .in_host_valid(in_host_valid),
      .out_host_ready(out_host_ready), .out_host_data(out_host_data),
      .out_host_valid(out_host_valid), .in_host_ready(in_host_ready),
      .out_proto_err(out_proto_err)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a rising oe presents a read byte; valid&ready at a negedge is a host pop at the next edge.
   always @(negedge in_clk) begin
      if (out_ftdi_data_oe && !oe_prev) begin
         if (exp_rd_q.size() == 0) check("rd_unexpected", out_ftdi_data, 8'hxx);
         else check("rd_byte", out_ftdi_data, exp_rd_q.pop_front());
      end
      oe_prev = out_ftdi_data_oe;
      if (out_host_valid && in_host_ready) begin
         if (exp_tx_q.size() == 0) check("tx_unexpected", out_host_data, 8'hxx);
         else check("tx_byte", out_host_data, exp_tx_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic host_push(input logic [7:0] b);
      @(posedge in_clk); #1 in_host_valid = 1'b1; in_host_data = b;
      @(posedge in_clk); #1 in_host_valid = 1'b0;
   endtask

   task automatic host_pop();
      @(posedge in_clk); #1 in_host_ready = 1'b1;
      @(posedge in_clk); #1 in_host_ready = 1'b0;
   endtask

   // rd high for n clock edges; returns just after the edge that sees rd low.
   task automatic ftdi_read(input int n);
      @(posedge in_clk); #1 in_ftdi_rd = 1'b1;
      @(posedge in_clk);
      @(negedge in_clk);
      check("rd_oe_during", out_ftdi_data_oe, 1'b1);
      check("rd_rxf_during", out_ftdi_rxf, 1'b0);
      repeat (n - 1) @(posedge in_clk);
      #1 in_ftdi_rd = 1'b0;
      @(posedge in_clk);
   endtask

   // wr high for n edges: first edge sees 'first', later edges see 'last'; bus changes after wr falls.
   task automatic ftdi_write(input logic [7:0] first, input logic [7:0] last, input int n);
      @(posedge in_clk); #1 in_ftdi_wr = 1'b1; in_ftdi_data = first;
      @(posedge in_clk); #1 in_ftdi_data = last;
      repeat (n - 1) @(posedge in_clk);
      #1 in_ftdi_wr = (n == 1) ? 1'b0 : 1'b0; in_ftdi_data = 8'hEE;
      @(posedge in_clk);
   endtask

   initial begin
      #1 in_rst = 1'b1;
      #2;
      check("rst_rxf", out_ftdi_rxf, 1'b0);
      check("rst_txe", out_ftdi_txe, 1'b0);
      check("rst_data", out_ftdi_data, 8'h00);
      check("rst_oe", out_ftdi_data_oe, 1'b0);
      check("rst_host_ready", out_host_ready, 1'b0);
      check("rst_host_valid", out_host_valid, 1'b0);
      check("rst_err", out_proto_err, 1'b0);
      repeat (2) @(posedge in_clk);
      #1 in_rst = 1'b0;
      @(negedge in_clk);
      check("rel_txe_before", out_ftdi_txe, 1'b0);
`ifndef FTDI_EMU_LOOPBACK_EN
      check("rel_ready_before", out_host_ready, 1'b0);
`endif
      @(negedge in_clk);
      check("rel_txe_after", out_ftdi_txe, 1'b1);

`ifdef FTDI_EMU_LOOPBACK_EN
      exp_rd_q.push_back(8'h5A);
      ftdi_write(8'h5A, 8'h5A, 2);
      repeat (4) @(negedge in_clk);
      check("lb_rxf", out_ftdi_rxf, 1'b1);
      check("lb_host_ready", out_host_ready, 1'b0);
      check("lb_host_valid", out_host_valid, 1'b0);
      ftdi_read(2);
      repeat (PRE + 1) @(negedge in_clk);
      check("lb_rxf_empty", out_ftdi_rxf, 1'b0);
      check("lb_err", out_proto_err, 1'b0);
`else
      check("rel_ready_after", out_host_ready, 1'b1);

      // Single byte read, FIFO empties.
      exp_rd_q.push_back(8'hA5);
      host_push(8'hA5);
      @(negedge in_clk);
      check("a5_rxf_before", out_ftdi_rxf, 1'b1);
      ftdi_read(3);
      for (int i = 0; i < PRE + 2; i++) begin
         @(negedge in_clk);
         check("a5_rxf_after", out_ftdi_rxf, 1'b0);
         check("a5_oe_after", out_ftdi_data_oe, 1'b0);
      end

      // Two bytes: rxf low for exactly PRE cycles after the first read.
      exp_rd_q.push_back(8'h11);
      exp_rd_q.push_back(8'h22);
      host_push(8'h11);
      host_push(8'h22);
      ftdi_read(2);
      for (int i = 0; i < PRE; i++) begin
         @(negedge in_clk);
         check("pre_rxf_low", out_ftdi_rxf, 1'b0);
      end
      @(negedge in_clk);
      check("pre_rxf_back", out_ftdi_rxf, 1'b1);
      ftdi_read(1);
      repeat (PRE) @(posedge in_clk);

      // Write with the bus changing mid-strobe: the last sample with wr high is kept.
      exp_tx_q.push_back(8'h3C);
      ftdi_write(8'h77, 8'h3C, 2);
      @(negedge in_clk);
      check("w3c_valid", out_host_valid, 1'b1);
      check("w3c_data", out_host_data, 8'h3C);
      check("w3c_txe_pre0", out_ftdi_txe, 1'b0);
      @(negedge in_clk);
      check("w3c_txe_pre1", out_ftdi_txe, 1'b0);
      @(negedge in_clk);
      check("w3c_txe_back", out_ftdi_txe, 1'b1);
      host_pop();

      // Fill the TX FIFO with 0..15 and no host pops.
      for (int i = 0; i < 16; i++) begin
         exp_tx_q.push_back(8'(i));
         ftdi_write(8'(i), 8'(i), 1);
         repeat (PRE) @(posedge in_clk);
      end
      repeat (PRE + 1) begin
         @(negedge in_clk);
         check("full_txe_low", out_ftdi_txe, 1'b0);
      end
      host_pop();
      @(negedge in_clk);
      check("full_txe_restored", out_ftdi_txe, 1'b1);
      @(posedge in_clk); #1 in_host_ready = 1'b1;
      repeat (15) @(posedge in_clk);
      #1 in_host_ready = 1'b0;
      @(negedge in_clk);
      check("drain_valid", out_host_valid, 1'b0);
      check("err_clean", out_proto_err, 1'b0);

      // Read while RX is empty: sticky error, nothing driven, FIFO untouched.
      @(posedge in_clk); #1 in_ftdi_rd = 1'b1;
      @(posedge in_clk); #1 in_ftdi_rd = 1'b0;
      @(negedge in_clk);
      check("empty_rd_err", out_proto_err, 1'b1);
      check("empty_rd_oe", out_ftdi_data_oe, 1'b0);
      check("empty_rd_rxf", out_ftdi_rxf, 1'b0);
      check("empty_rd_ready", out_host_ready, 1'b1);
      exp_rd_q.push_back(8'hE5);
      host_push(8'hE5);
      ftdi_read(2);
      repeat (PRE) @(posedge in_clk);
      @(negedge in_clk);
      check("err_sticky", out_proto_err, 1'b1);
      check("e5_rxf_empty", out_ftdi_rxf, 1'b0);

      // Reset in the middle of a read strobe.
      exp_rd_q.push_back(8'hB7);
      host_push(8'hB7);
      @(posedge in_clk); #1 in_ftdi_rd = 1'b1;
      @(posedge in_clk);
      @(negedge in_clk);
      check("mid_oe", out_ftdi_data_oe, 1'b1);
      #1 in_rst = 1'b1;
      #1;
      check("mid_rst_oe", out_ftdi_data_oe, 1'b0);
      check("mid_rst_rxf", out_ftdi_rxf, 1'b0);
      check("mid_rst_data", out_ftdi_data, 8'h00);
      check("mid_rst_err", out_proto_err, 1'b0);
      in_ftdi_rd = 1'b0;
      @(posedge in_clk); #1 in_rst = 1'b0;
      repeat (3) @(negedge in_clk);
      check("mid_rel_rxf", out_ftdi_rxf, 1'b0);
      check("mid_rel_ready", out_host_ready, 1'b1);

      // rd and wr together: both serviced, error flagged.
      exp_rd_q.push_back(8'hC1);
      exp_tx_q.push_back(8'hD2);
      host_push(8'hC1);
      @(posedge in_clk); #1 in_ftdi_rd = 1'b1; in_ftdi_wr = 1'b1; in_ftdi_data = 8'hD2;
      repeat (2) @(posedge in_clk);
      #1 in_ftdi_rd = 1'b0; in_ftdi_wr = 1'b0; in_ftdi_data = 8'h00;
      @(posedge in_clk);
      @(negedge in_clk);
      check("both_err", out_proto_err, 1'b1);
      check("both_tx_valid", out_host_valid, 1'b1);
      repeat (PRE) @(posedge in_clk);
      host_pop();
      @(negedge in_clk);
      check("both_rx_empty", out_ftdi_rxf, 1'b0);
`endif

      repeat (2) @(negedge in_clk);
      check("rd_q_drained", 8'(exp_rd_q.size()), 8'd0);
      check("tx_q_drained", 8'(exp_tx_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
